// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver.
//
// Runs whole-scan commands against an IEEE 1149.1 TAP: TAP reset (op 0),
// IR scan (op 1), DR scan (op 2) and idle clocks (op 3). It generates
// TCK/TMS/TDI from clk, samples TDO and returns the captured bits. Every
// command starts and ends parked in Run-Test/Idle (TCK=0, TMS=0).
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_len, cmd_data
//                         (TDI bits, LSB shifted first)
//   rsp_valid/rsp_ready   response handshake; rsp_data holds the captured
//                         TDO bits, bit0 = first captured, right-aligned
//   busy                  high while the sequencer is not IDLE
//   TCK, TMS, TDI, TDO    JTAG pins
//
// Timing: each TCK period is 2*CLK_DIV clk. TMS/TDI change on the clk edge
// where TCK falls, TDO is sampled on the clk edge where TCK rises.
//
// Optional build macro JTAG_MASTER_RTI_EN: adds parameter RTI_CYCLES and
// appends that many TMS=0 TCKs after every IR/DR scan trailer.
module jtag_master #(
  parameter int MAX_LEN    = 64,
  parameter int CLK_DIV    = 4,
`ifdef JTAG_MASTER_RTI_EN
  parameter int RTI_CYCLES = 1,
`endif
  parameter int LEN_W      = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

`ifdef JTAG_MASTER_RTI_EN
  localparam int TRL_SCAN = 2 + RTI_CYCLES;
`else
  localparam int TRL_SCAN = 2;
`endif
  localparam int CNT_MAX = (MAX_LEN > TRL_SCAN) ? ((MAX_LEN > 6) ? MAX_LEN : 6)
                                                : ((TRL_SCAN > 6) ? TRL_SCAN : 6);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_IDLE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RESP} state_t;

  // Lengths beyond MAX_LEN saturate to MAX_LEN.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_LEN)) return CNT_W'(MAX_LEN);
    return CNT_W'(len);
  endfunction

  // Number of TCKs spent in one sequencer phase.
  function automatic logic [CNT_W-1:0] phase_len(input state_t st, input logic [1:0] op,
                                                 input logic [CNT_W-1:0] n);
    case (st)
      S_HDR:   return (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
      S_SHIFT: return n;
      S_TRL: begin
        if (op == OP_RST)  return CNT_W'(6);
        if (op == OP_IDLE) return n;
        return CNT_W'(TRL_SCAN);
      end
      default: return '0;
    endcase
  endfunction

  // TMS for bit k of a phase: IR header 1,1,0,0 / DR header 1,0,0;
  // last shift bit exits; scan trailer starts with 1 (Update), then 0s;
  // TAP reset is five 1s then a 0; idle clocks are all 0.
  function automatic logic tms_bit(input state_t st, input logic [1:0] op,
                                   input logic [CNT_W-1:0] k, input logic [CNT_W-1:0] n);
    case (st)
      S_HDR:   return (op == OP_IR) ? (k < CNT_W'(2)) : (k == '0);
      S_SHIFT: return k == n - CNT_W'(1);
      S_TRL:   return (op == OP_RST) ? (k < CNT_W'(5)) : ((op == OP_IDLE) ? 1'b0 : (k == '0));
      default: return 1'b0;
    endcase
  endfunction

  state_t             state, state_nx;
  logic               alive, zero_r, is_zero;
  logic [1:0]         op_r, op_nx;
  logic [CNT_W-1:0]   len_r, len_nx, bit_cnt, cnt_nx, cur_len;
  logic [DIV_W-1:0]   div_cnt;
  logic [MAX_LEN-1:0] data_r, cap_r;
  logic               accept, scanning, tick, rise, fall, last_bit, drive, tms_nx, tdi_nx;

  assign busy      = state != S_IDLE;
  assign cmd_ready = alive && (state == S_IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  // Zero-length commands pass through the sequencer without toggling TCK.
  assign scanning  = ((state == S_HDR) || (state == S_SHIFT) || (state == S_TRL)) && !zero_r;
  assign tick      = div_cnt == DIV_LAST;
  assign rise      = scanning && !TCK && tick;
  assign fall      = scanning && TCK && tick;
  assign cur_len   = phase_len(state, op_r, len_r);
  assign last_bit  = bit_cnt == cur_len - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = ((cmd_op == OP_RST) || (cmd_op == OP_IDLE)) ? S_TRL : S_HDR;
      S_HDR:   if (zero_r) state_nx = S_RESP;
               else if (fall && last_bit) state_nx = S_SHIFT;
      S_SHIFT: if (fall && last_bit) state_nx = S_TRL;
      S_TRL:   if (zero_r || (fall && last_bit)) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Values for the next bit, applied on accept or on a TCK falling edge.
  always_comb begin
    op_nx   = accept ? cmd_op : op_r;
    len_nx  = accept ? clamp_len(cmd_len) : len_r;
    is_zero = accept && (cmd_op != OP_RST) && (clamp_len(cmd_len) == '0);
    cnt_nx  = (state_nx != state) ? '0 : bit_cnt + CNT_W'(1);
    drive   = accept || fall;
    tms_nx  = is_zero ? 1'b0 : tms_bit(state_nx, op_nx, cnt_nx, len_nx);
    tdi_nx  = (state_nx == S_SHIFT) && data_r[0];
  end

  // ---- control pipeline: TCK divider, pin drive, response handshake ----
  always_ff @(posedge clk) begin
    if (reset) begin
      alive     <= 1'b0;
      TCK       <= 1'b0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      zero_r    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        TCK     <= 1'b0;
        div_cnt <= '0;
        zero_r  <= is_zero;
      end else if (scanning) begin
        if (tick) begin
          div_cnt <= '0;
          TCK     <= !TCK;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
      end
      if (drive) begin
        bit_cnt <= cnt_nx;
        TMS     <= tms_nx;
        TDI     <= tdi_nx;
      end
      // Captured bits entered from the top; shift down to right-align.
      if (state == S_RESP) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_r >> (CNT_W'(MAX_LEN) - len_r);
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // ---- data pipeline: command latch, TDI shift-out, TDO capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= cmd_op;
      len_r  <= clamp_len(cmd_len);
      data_r <= cmd_data;
      cap_r  <= '0;
    end else begin
      if (fall && (state_nx == S_SHIFT)) data_r <= data_r >> 1;
      if (rise && (state == S_SHIFT))    cap_r  <= {TDO, cap_r[MAX_LEN-1:1]};
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural IEEE 1149.1 TAP target drives TDO,
// a monitor records TMS/TDI at every TCK rise, and each command's expected
// pin sequence, latency and response are built from the command itself.
module tb_jtag_master;
  localparam int MAX_LEN = 64;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 7;

  logic              clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0, TDO = 1'b0;
  logic              cmd_ready, rsp_valid, busy, TCK, TMS, TDI;
  logic [1:0]        cmd_op = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [63:0]       cmd_data = '0;
  logic [63:0]       rsp_data;
  int checks = 0, failures = 0;

  jtag_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO));

  always #5 clk = ~clk;

  // TAP target model
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
                            T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PADR;
      T_PADR:  return m ? T_EX2DR : T_PADR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PAIR;
      T_PAIR:  return m ? T_EX2IR : T_PAIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      T_UPIR:  return m ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  tap_t        tap = T_PADR;
  logic        sel64 = 1'b0;          // 0: 1-bit bypass DR capturing 0; 1: 64-bit DR
  logic [63:0] dr_reg = 64'h1, dr_sr = '0;
  logic [5:0]  ir = '0, ir_sr = '0;
  int          n_rise = 0, n_fall = 0, rise_base = 0, fall_base = 0;
  logic [127:0] o_tms = '0, o_tdi = '0, e_tms, e_tdi;
  int          e_n;

  always @(posedge TCK) begin
    if ((n_rise - rise_base) >= 0 && (n_rise - rise_base) < 128) begin
      o_tms[n_rise - rise_base] <= TMS;
      o_tdi[n_rise - rise_base] <= TDI;
    end
    n_rise <= n_rise + 1;
    case (tap)
      T_CAPDR: dr_sr <= sel64 ? dr_reg : 64'h0;
      T_SHDR:  dr_sr <= sel64 ? {TDI, dr_sr[63:1]} : {63'h0, TDI};
      T_UPDR:  if (sel64) dr_reg <= dr_sr;
      T_CAPIR: ir_sr <= 6'b000001;
      T_SHIR:  ir_sr <= {TDI, ir_sr[5:1]};
      T_UPIR:  ir <= ir_sr;
      default: ;
    endcase
    tap <= tap_next(tap, TMS);
  end

  always @(negedge TCK) begin
    n_fall <= n_fall + 1;
    TDO    <= (tap == T_SHDR) ? dr_sr[0] : ((tap == T_SHIR) ? ir_sr[0] : 1'b0);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic epush(input logic m, input logic d);
    e_tms[e_n] = m;
    e_tdi[e_n] = d;
    e_n++;
  endtask

  // Expected pin sequence at each TCK rise, straight from the command.
  task automatic build_exp(input logic [1:0] op, input int n, input logic [63:0] data);
    e_tms = '0; e_tdi = '0; e_n = 0;
    case (op)
      2'd0: begin repeat (5) epush(1'b1, 1'b0); epush(1'b0, 1'b0); end
      2'd3: repeat (n) epush(1'b0, 1'b0);
      default: if (n > 0) begin
        if (op == 2'd1) epush(1'b1, 1'b0);
        epush(1'b1, 1'b0); epush(1'b0, 1'b0); epush(1'b0, 1'b0);
        for (int i = 0; i < n; i++) epush(i == n - 1, data[i]);
        epush(1'b1, 1'b0); epush(1'b0, 1'b0);
`ifdef JTAG_MASTER_RTI_EN
        epush(1'b0, 1'b0);
`endif
      end
    endcase
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len, input logic [63:0] data);
    int g = 0;
    @(negedge clk);
    cmd_op = op; cmd_len = LEN_W'(len); cmd_data = data; cmd_valid = 1'b1;
    rise_base = n_rise; fall_base = n_fall;
    while (cmd_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    check("accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input int len,
                         input logic [63:0] data, input logic [63:0] exp_rsp, input int hold);
    int n, lat, exp_lat;
    logic [127:0] m;
    logic stable;
    logic [63:0] held;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    build_exp(op, n, data);
    send_cmd(op, len, data);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    exp_lat = (e_n == 0) ? 2 : 2 * CLK_DIV * e_n + 1;
    m = (128'h1 << e_n) - 128'h1;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rsp_data"}, rsp_data, exp_rsp);
    check({tag, " tck_rises"}, n_rise - rise_base, e_n);
    check({tag, " tck_falls"}, n_fall - fall_base, e_n);
    check({tag, " tms_seq"}, o_tms & m, e_tms);
    check({tag, " tdi_seq"}, o_tdi & m, e_tdi);
    stable = 1'b1; held = rsp_data;
    repeat (hold) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || TCK !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({tag, " hold_stable"}, stable, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " parked"}, {rsp_valid, TCK, TMS, busy, cmd_ready}, 5'b00001);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  op;
    int len, n, g;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset pins", {cmd_ready, TCK, TMS, TDI, rsp_valid, busy}, 6'b001000);
    check("reset rsp_data", rsp_data, 64'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("ready after reset", cmd_ready, 1'b1);

    run_cmd("tap_reset", 2'd0, 0, 64'h0, 64'h0, 0);
    check("tap in rti", tap, T_RTI);

    sel64 = 1'b0;
    run_cmd("dr8", 2'd2, 8, 64'hA5, 64'h4A, 0);
    run_cmd("ir6", 2'd1, 6, 64'h02, 64'h01, 0);
    check("ir value", ir, 6'h02);
    check("tap rti after ir", tap, T_RTI);

    sel64 = 1'b1;
    run_cmd("dr64a", 2'd2, 64, 64'hDEADBEEF_01234567, 64'h1, 0);
    run_cmd("dr64b", 2'd2, 64, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 0);
    sel64 = 1'b0;

    run_cmd("dr_len0", 2'd2, 0, 64'hFFFF, 64'h0, 0);
    run_cmd("ir_len0", 2'd1, 0, 64'hFFFF, 64'h0, 0);
    run_cmd("idle_len0", 2'd3, 0, 64'h0, 64'h0, 0);
    run_cmd("dr_len1", 2'd2, 1, 64'h1, 64'h0, 0);
    run_cmd("hold", 2'd2, 4, 64'hF, 64'hE, 10);
    d = 64'hF0F0_1234_8765_ABCD;
    run_cmd("clamp", 2'd2, 100, d, d << 1, 0);
    run_cmd("idle5", 2'd3, 5, 64'hFFFF, 64'h0, 0);

    // randomized DR scans / idle runs through the bypass target
    for (int it = 0; it < 12; it++) begin
      op  = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
      len = $urandom_range(0, 70);
      d   = {$urandom, $urandom};
      n   = (len > MAX_LEN) ? MAX_LEN : len;
      run_cmd("random", op, len, d,
              (op == 2'd2) ? ((d << 1) & ((n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << n) - 64'h1))) : 64'h0,
              $urandom_range(0, 3));
    end

    // reset in the middle of shift bit 3 of a 16-bit DR scan
    send_cmd(2'd2, 16, 64'h1234);
    g = 0;
    while ((n_rise - rise_base) < 7 && g < 1000) begin @(negedge clk); g++; end
    check("reached shift bit3", (n_rise - rise_base) >= 7, 1'b1);
    check("busy mid scan", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset pins", {TCK, TMS, busy, rsp_valid, cmd_ready}, 5'b01000);
    @(negedge clk); reset = 1'b0;
    run_cmd("tap_reset2", 2'd0, 0, 64'h0, 64'h0, 0);
    check("tap rti after reset2", tap, T_RTI);
    run_cmd("dr16", 2'd2, 16, 64'h1234, 64'h2468, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
